ram_access_arb: RTL and testbench

//   Requester-side front end for the flip-flop RAM: arbitrates CLIENT independent

---
 rtl/ram_access_arb_if.sv | 33 +++
 rtl/ram_access_arb.sv | 134 +++++++++++++
 tb/tb_ram_access_arb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arb_if.sv
// Bundle of requester and RAM-port signals for ram_access_arb.
// The slave modport is the arbiter's view. The master modport is the
// view of the environment that drives the requests and owns the RAM.
interface ram_access_arb_if #(
  parameter int DATA   = 16,
  parameter int DEPTH  = 4,
  parameter int CLIENT = 2
);
  localparam int ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CLIENT-1:0]           req_valid;
  logic [CLIENT-1:0]           req_ready;
  logic [CLIENT-1:0]           req_rw_;
  logic [CLIENT-1:0][ADDR-1:0] req_addr;
  logic [CLIENT-1:0][DATA-1:0] req_wdata;
  logic [CLIENT-1:0]           rsp_valid;
  logic [DATA-1:0]             rsp_rdata;
  logic                        ram_en;
  logic                        ram_rw_;
  logic [ADDR-1:0]             ram_addr;
  logic [DATA-1:0]             ram_wdata;
  logic [DATA-1:0]             ram_rdata;

  modport slave (
    input  req_valid, req_rw_, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_rw_, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_rw_, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_rw_, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_access_arb.sv
// Round-robin front end for a single-port flip-flop RAM.
// Several clients send requests to one registered RAM command. Each read
// response is steered back to the client that issued the read, after a
// fixed latency.
//
// Handshake: a request from client c is accepted in the cycle where
// req_valid[c] & req_ready[c] are both 1. req_ready is driven only from
// req_valid, the round-robin pointer and reset. A requester must hold
// its req_* fields stable until the request is accepted. Responses have
// no ready signal: rsp_valid is a one-cycle pulse that the client must
// take.
module ram_access_arb #(
  parameter  int DATA    = 16,
  parameter  int DEPTH   = 4,
  parameter  int CLIENT  = 2,
  parameter  int RAM_LAT = 0,
  localparam int ADDR    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CID     = (CLIENT > 1) ? $clog2(CLIENT) : 1
) (
  input  logic            clk,
  input  logic            reset,
  ram_access_arb_if.slave bus,
  output logic [CID-1:0]  dbg_rr_ptr_o
);

  logic [CID-1:0]              ptr_q, ptr_d;
  logic [CLIENT-1:0]           gnt;
  logic [CID-1:0]              gnt_id;
  logic                        hs;
  logic [CID:0]                cand;

  logic                        ram_en_q;
  logic                        ram_rw_q;
  logic [ADDR-1:0]             ram_addr_q;
  logic [DATA-1:0]             ram_wdata_q;

  // One stage per cycle between command issue and rdata sampling.
  logic [RAM_LAT:0]            rd_vld_q;
  logic [RAM_LAT:0][CID-1:0]   rd_id_q;

  logic [CLIENT-1:0]           rsp_valid_q;
  logic [DATA-1:0]             rsp_rdata_q;

  // Round-robin grant. Scan offsets from high to low so that the
  // lowest offset from ptr_q wins. A grant is only given to a valid
  // client, so a grant is the same as a handshake.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hs     = 1'b0;
    cand   = '0;
    if (!reset) begin
      for (int i = CLIENT - 1; i >= 0; i--) begin
        cand = {1'b0, ptr_q} + (CID+1)'(i);
        if (cand >= (CID+1)'(CLIENT)) cand = cand - (CID+1)'(CLIENT);
        if (bus.req_valid[cand[CID-1:0]]) begin
          gnt                 = '0;
          gnt[cand[CID-1:0]]  = 1'b1;
          gnt_id              = cand[CID-1:0];
          hs                  = 1'b1;
        end
      end
    end
  end

  // After a handshake the pointer moves to the client just past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_id == CID'(CLIENT - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Register the pointer and the RAM command. When idle, rw_ returns to
  // read, and addr/wdata keep their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      ram_en_q <= hs;
      if (hs) begin
        ram_rw_q    <= bus.req_rw_[gnt_id];
        ram_addr_q  <= bus.req_addr[gnt_id];
        ram_wdata_q <= bus.req_wdata[gnt_id];
      end else begin
        ram_rw_q    <= 1'b1;
      end
    end
  end

  // Track each read in flight together with its issuing client id.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= '0;
      rd_id_q  <= '0;
    end else begin
      rd_vld_q[0] <= hs & bus.req_rw_[gnt_id];
      rd_id_q[0]  <= gnt_id;
      for (int k = 1; k <= RAM_LAT; k++) begin
        rd_vld_q[k] <= rd_vld_q[k-1];
        rd_id_q[k]  <= rd_id_q[k-1];
      end
    end
  end

  // Sample rdata when the RAM presents it, and pulse the owner's
  // rsp_valid. Data is forced to zero when there is no response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      if (rd_vld_q[RAM_LAT]) begin
        rsp_valid_q[rd_id_q[RAM_LAT]] <= 1'b1;
        rsp_rdata_q                   <= bus.ram_rdata;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_rw_   = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_rr_ptr_o  = ptr_q;

endmodule

// File: tb/tb_ram_access_arb.sv
// Testbench for ram_access_arb. One instance uses combinational RAM
// rdata and the other uses registered RAM rdata. Both instances get the
// same request stream. A transaction-level model predicts the expected
// behaviour. Grants come from "nearest valid client at or after the
// pointer". Commands are applied to a reference memory in grant order.
// Reads are queued with their due cycle.
module tb_ram_access_arb;
  localparam int DATA   = 16;
  localparam int DEPTH  = 4;
  localparam int CLIENT = 2;
  localparam int EW     = 32 + 1 + DATA;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_r;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [CLIENT-1:0]       rv, rrw;
  logic [CLIENT-1:0][1:0]  raddr;
  logic [CLIENT-1:0][15:0] rwd;
  logic                    dbg0, dbg1;

  ram_access_arb_if #(.DATA(DATA), .DEPTH(DEPTH), .CLIENT(CLIENT)) bi0 ();
  ram_access_arb_if #(.DATA(DATA), .DEPTH(DEPTH), .CLIENT(CLIENT)) bi1 ();

  assign bi0.req_valid = rv;    assign bi1.req_valid = rv;
  assign bi0.req_rw_   = rrw;   assign bi1.req_rw_   = rrw;
  assign bi0.req_addr  = raddr; assign bi1.req_addr  = raddr;
  assign bi0.req_wdata = rwd;   assign bi1.req_wdata = rwd;

  ram_access_arb #(.DATA(DATA), .DEPTH(DEPTH), .CLIENT(CLIENT), .RAM_LAT(0)) dut0 (
    .clk(clk), .reset(reset_r), .bus(bi0.slave), .dbg_rr_ptr_o(dbg0));
  ram_access_arb #(.DATA(DATA), .DEPTH(DEPTH), .CLIENT(CLIENT), .RAM_LAT(1)) dut1 (
    .clk(clk), .reset(reset_r), .bus(bi1.slave), .dbg_rr_ptr_o(dbg1));

  // ---------------- RAM models ----------------
  logic [15:0] mem0 [DEPTH];
  logic [15:0] mem1 [DEPTH];
  logic [15:0] rdata1_q;

  assign bi0.ram_rdata = mem0[bi0.ram_addr];
  always @(posedge clk)
    if (bi0.ram_en && !bi0.ram_rw_) mem0[bi0.ram_addr] <= bi0.ram_wdata;

  always @(posedge clk) begin
    if (bi1.ram_en && !bi1.ram_rw_) mem1[bi1.ram_addr] <= bi1.ram_wdata;
    if (bi1.ram_en && bi1.ram_rw_)  rdata1_q <= mem1[bi1.ram_addr];
  end
  assign bi1.ram_rdata = rdata1_q;

  // ---------------- reference model / scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          m_ptr   = 0;
  logic        m_en    = 1'b0;
  logic        m_rw    = 1'b1;
  logic [1:0]  m_addr  = '0;
  logic [15:0] m_wd    = '0;
  logic [15:0] ref_mem [DEPTH];
  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  bit          rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_rsp(input int k, input logic [1:0] obs_v, input logic [15:0] obs_d);
    logic [EW-1:0] e;
    logic [1:0]    ev;
    logic [15:0]   ed;
    ev = '0; ed = '0; e = '0;
    if (k == 0) begin
      if (exp0_q.size() > 0 && exp0_q[0][EW-1 -: 32] == 32'(cyc)) begin
        e = exp0_q.pop_front(); ev = 2'b01 << e[DATA]; ed = e[DATA-1:0];
      end
    end else begin
      if (exp1_q.size() > 0 && exp1_q[0][EW-1 -: 32] == 32'(cyc)) begin
        e = exp1_q.pop_front(); ev = 2'b01 << e[DATA]; ed = e[DATA-1:0];
      end
    end
    chk($sformatf("rsp_valid_lat%0d", k), 32'(obs_v), 32'(ev));
    chk($sformatf("rsp_rdata_lat%0d", k), 32'(obs_d), 32'(ed));
  endtask

  task automatic check_cmd(input int k, input logic [1:0] rdy, input logic [1:0] exp_rdy,
                           input logic en, input logic rw, input logic [1:0] addr,
                           input logic [15:0] wd, input logic ptr);
    chk($sformatf("req_ready_lat%0d", k), 32'(rdy), 32'(exp_rdy));
    chk($sformatf("ram_en_lat%0d", k), 32'(en), 32'(m_en));
    chk($sformatf("ram_rw_lat%0d", k), 32'(rw), 32'(m_rw));
    chk($sformatf("ram_addr_lat%0d", k), 32'(addr), 32'(m_addr));
    chk($sformatf("ram_wdata_lat%0d", k), 32'(wd), 32'(m_wd));
    chk($sformatf("rr_ptr_lat%0d", k), 32'(ptr), 32'(m_ptr));
  endtask

  // ---------------- driver ----------------
  // One clock cycle. Check the outputs at the negedge, then advance the
  // model and the requesters just after the posedge.
  task automatic step();
    int          g, best, d;
    logic [1:0]  exp_rdy;
    logic        g_rw;
    logic [1:0]  g_addr;
    logic [15:0] g_wd;
    @(negedge clk);
    g = -1; best = CLIENT;
    if (!reset_r)
      for (int c = 0; c < CLIENT; c++)
        if (rv[c]) begin
          d = (c - m_ptr + CLIENT) % CLIENT;
          if (d < best) begin best = d; g = c; end
        end
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
    check_cmd(0, bi0.req_ready, exp_rdy, bi0.ram_en, bi0.ram_rw_, bi0.ram_addr, bi0.ram_wdata, dbg0);
    check_cmd(1, bi1.req_ready, exp_rdy, bi1.ram_en, bi1.ram_rw_, bi1.ram_addr, bi1.ram_wdata, dbg1);
    check_rsp(0, bi0.rsp_valid, bi0.rsp_rdata);
    check_rsp(1, bi1.rsp_valid, bi1.rsp_rdata);
    g_rw = 1'b0; g_addr = '0; g_wd = '0;
    if (g >= 0) begin g_rw = rrw[g]; g_addr = raddr[g]; g_wd = rwd[g]; end
    @(posedge clk);
    #1;
    if (reset_r) begin
      exp0_q.delete(); exp1_q.delete();
      m_ptr = 0; m_en = 1'b0; m_rw = 1'b1; m_addr = '0; m_wd = '0;
    end else if (g >= 0) begin
      m_en = 1'b1; m_rw = g_rw; m_addr = g_addr; m_wd = g_wd;
      if (g_rw) begin
        exp0_q.push_back({32'(cyc + 2), 1'(g), ref_mem[g_addr]});
        exp1_q.push_back({32'(cyc + 3), 1'(g), ref_mem[g_addr]});
      end else begin
        ref_mem[g_addr] = g_wd;
      end
      m_ptr = (g + 1) % CLIENT;
      rv[g] = 1'b0;
    end else begin
      m_en = 1'b0; m_rw = 1'b1;
    end
    cyc++;
    if (rand_mode)
      for (int c = 0; c < CLIENT; c++)
        if (!rv[c] && $urandom_range(0, 99) < 70) begin
          rv[c]    = 1'b1;
          rrw[c]   = 1'($urandom_range(0, 1));
          raddr[c] = 2'($urandom_range(0, DEPTH - 1));
          rwd[c]   = 16'($urandom);
        end
  endtask

  task automatic req(input int c, input logic rw, input logic [1:0] a, input logic [15:0] wd);
    rv[c] = 1'b1; rrw[c] = rw; raddr[c] = a; rwd[c] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until every pending request has been accepted, within a bound.
  task automatic drain();
    for (int i = 0; i < 50 && rv != '0; i++) step();
    chk("drain_pending", 32'(rv), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_r = 1'b1; rv = '0; rrw = '0; raddr = '0; rwd = '0;
    idle(3);
    chk("reset_ram_addr", 32'(bi0.ram_addr), 32'd0);
    chk("reset_ram_wdata", 32'(bi1.ram_wdata), 32'd0);
    reset_r = 1'b0;

    // Preload the RAM through the arbiter. RAM[2] gets 16'hBEEF.
    for (int a = 0; a < DEPTH; a++) begin
      req(0, 1'b0, 2'(a), (a == 2) ? 16'hBEEF : 16'($urandom));
      drain();
    end
    idle(4);

    // Single read of RAM[2] from client 0 (both read latencies).
    req(0, 1'b1, 2'd2, 16'h0);
    idle(5);

    // Both clients request continuously: grants should alternate.
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CLIENT; c++)
        if (!rv[c]) req(c, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
      step();
    end
    drain();
    idle(4);

    // Write then read the same address, from different clients.
    req(0, 1'b0, 2'd1, 16'h1234);
    step();
    req(1, 1'b1, 2'd1, 16'h0);
    idle(5);

    // Back-to-back reads of addresses 0 to 3 from client 1.
    for (int a = 0; a < DEPTH; a++) begin
      req(1, 1'b1, 2'(a), 16'h0);
      step();
    end
    idle(5);

    // Reset while a read is in flight. The first grant after reset
    // goes to client 0.
    req(0, 1'b1, 2'd3, 16'h0);
    step();
    reset_r = 1'b1;
    step();
    reset_r = 1'b0;
    req(0, 1'b1, 2'd0, 16'h0);
    req(1, 1'b1, 2'd2, 16'h0);
    step();
    drain();
    idle(5);

    // Random traffic.
    rand_mode = 1'b1;
    idle(400);
    rand_mode = 1'b0;
    drain();
    idle(6);
    chk("exp_q_lat0_empty", 32'(exp0_q.size()), 32'd0);
    chk("exp_q_lat1_empty", 32'(exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
